// File: rtl/acc_run_ctrl.sv
// acc_run_ctrl: run controller for an ap_ctrl_hs accelerator.
//
// It accepts a run command of N invocations and starts the accelerator N times. For each
// invocation it captures the latest scalar result and forwards it on a valid/ready stream.
// When all invocations are done it pulses o_run_done.
//
// Optional feature macro: ACC_RUN_CTRL_TIMEOUT_EN. When it is defined, a watchdog is built.
// If the accelerator stays in WAIT for TIMEOUT cycles without ap_done, the run is aborted
// and the sticky error flag o_err is set. When the macro is undefined, o_err is tied to 0.
//
// Ports:
//   i_clk, i_resetn           clock; asynchronous active-low reset (release synchronised)
//   i_cmd_valid, o_cmd_ready  run request handshake; i_cmd_count = number of invocations
//   o_ap_start, i_ap_ready,   accelerator ap_ctrl_hs bus (i_ap_idle is status only)
//   i_ap_done, i_ap_idle
//   i_data_in, i_vld_in       accelerator scalar output and its valid
//   o_data_out, o_vld_out,    result stream towards the adapter
//   i_rdy_in
//   o_busy                    controller not idle
//   o_run_done                one-cycle pulse at the end of a run
//   o_err                     sticky watchdog timeout flag
module acc_run_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [CNT_WIDTH-1:0]  i_cmd_count,
    output logic                  o_ap_start,
    input  logic                  i_ap_ready,
    input  logic                  i_ap_done,
    input  logic                  i_ap_idle,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic                  i_vld_in,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_vld_out,
    input  logic                  i_rdy_in,
    output logic                  o_busy,
    output logic                  o_run_done,
    output logic                  o_err
);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StOut} state_e;

    // Reset synchroniser: assertion is immediate, release takes two clock edges.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    state_e                r_state;
    logic [CNT_WIDTH-1:0]  r_remaining;
    logic                  r_ever_valid;
    logic [DATA_WIDTH-1:0] r_data_reg;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_vld_out;
    logic                  r_ap_start;
    logic                  r_run_done;
    logic                  w_step;
    logic                  w_last;
    logic                  w_timeout;
    logic                  w_unused;

`ifdef ACC_RUN_CTRL_TIMEOUT_EN
    localparam int unsigned WdWidth = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [WdWidth-1:0] r_wd_cnt;
    logic               r_err;

    assign w_timeout = (r_state == StWait) && !i_ap_done &&
                       (r_wd_cnt == WdWidth'(TIMEOUT - 1));
    assign o_err     = r_err;
    assign w_unused  = i_ap_idle;
`else
    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
    assign w_unused  = i_ap_idle ^ (TIMEOUT == 0);
`endif

    // w_step: the current invocation is finished, either because its output was handed
    // off or because it produced no output. In START with ap_ready, ever_valid counts as
    // already cleared, so only a same-cycle vld_in can give an output.
    always_comb begin
        w_step = 1'b0;
        case (r_state)
            StStart: w_step = i_ap_ready & i_ap_done & ~i_vld_in;
            StWait:  w_step = i_ap_done & ~i_vld_in & ~r_ever_valid;
            StOut:   w_step = i_rdy_in;
            default: w_step = 1'b0;
        endcase
    end

    assign w_last = (r_remaining == CNT_WIDTH'(1));

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= StIdle;
            r_remaining  <= '0;
            r_ever_valid <= 1'b0;
            r_data_reg   <= '0;
            r_data_out   <= '0;
            r_vld_out    <= 1'b0;
            r_ap_start   <= 1'b0;
            r_run_done   <= 1'b0;
`ifdef ACC_RUN_CTRL_TIMEOUT_EN
            r_wd_cnt     <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_run_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_cmd_valid) begin
                        r_remaining <= i_cmd_count;
`ifdef ACC_RUN_CTRL_TIMEOUT_EN
                        r_err       <= 1'b0;
`endif
                        if (i_cmd_count == '0) begin
                            r_run_done <= 1'b1;
                        end else begin
                            r_state    <= StStart;
                            r_ap_start <= 1'b1;
                        end
                    end
                end
                StStart: begin
                    if (i_ap_ready) begin
                        r_ap_start   <= 1'b0;
                        r_ever_valid <= 1'b0;
                        if (i_ap_done) begin
                            if (i_vld_in) begin
                                r_data_out <= i_data_in;
                                r_vld_out  <= 1'b1;
                                r_state    <= StOut;
                            end
                        end else begin
                            r_state <= StWait;
`ifdef ACC_RUN_CTRL_TIMEOUT_EN
                            r_wd_cnt <= '0;
`endif
                        end
                    end
                end
                StWait: begin
                    if (i_ap_done) begin
                        if (i_vld_in) begin
                            r_data_out <= i_data_in;
                            r_vld_out  <= 1'b1;
                            r_state    <= StOut;
                        end else if (r_ever_valid) begin
                            r_data_out <= r_data_reg;
                            r_vld_out  <= 1'b1;
                            r_state    <= StOut;
                        end
                    end else begin
                        if (i_vld_in) begin
                            r_data_reg   <= i_data_in;
                            r_ever_valid <= 1'b1;
                        end
`ifdef ACC_RUN_CTRL_TIMEOUT_EN
                        r_wd_cnt <= r_wd_cnt + WdWidth'(1);
`endif
                    end
                end
                StOut: begin
                    if (i_rdy_in) begin
                        r_vld_out <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase

            // Remaining is only decremented from a non-zero value, so it cannot wrap.
            if (w_step) begin
                r_remaining <= r_remaining - CNT_WIDTH'(1);
                if (w_last) begin
                    r_state    <= StIdle;
                    r_run_done <= 1'b1;
                end else begin
                    r_state    <= StStart;
                    r_ap_start <= 1'b1;
                end
            end

            // A watchdog abort discards the remaining invocations of the run.
            if (w_timeout) begin
                r_state     <= StIdle;
                r_run_done  <= 1'b1;
                r_remaining <= '0;
`ifdef ACC_RUN_CTRL_TIMEOUT_EN
                r_err       <= 1'b1;
`endif
            end
        end
    end

    // Ready is held low until the internal reset has been released.
    assign o_cmd_ready = (r_state == StIdle) && w_rst_n;
    assign o_busy      = (r_state != StIdle);
    assign o_ap_start  = r_ap_start;
    assign o_vld_out   = r_vld_out;
    assign o_data_out  = r_data_out;
    assign o_run_done  = r_run_done;

endmodule

// File: tb/tb_acc_run_ctrl.sv
// tb_acc_run_ctrl: directed self-checking bench for acc_run_ctrl.
// Inputs are driven 1 time unit after the rising edge. Registered outputs are sampled there.
module tb_acc_run_ctrl;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_count;
    logic          ap_start;
    logic          ap_ready;
    logic          ap_done;
    logic          ap_idle;
    logic [DW-1:0] data_in;
    logic          vld_in;
    logic [DW-1:0] data_out;
    logic          vld_out;
    logic          rdy_in;
    logic          busy;
    logic          run_done;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;
    int starts;
    int guard;

    always #5 clk = ~clk;

    acc_run_ctrl #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW),
        .TIMEOUT    (16)
    ) u_dut (
        .i_clk       (clk),
        .i_resetn    (resetn),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_count (cmd_count),
        .o_ap_start  (ap_start),
        .i_ap_ready  (ap_ready),
        .i_ap_done   (ap_done),
        .i_ap_idle   (ap_idle),
        .i_data_in   (data_in),
        .i_vld_in    (vld_in),
        .o_data_out  (data_out),
        .o_vld_out   (vld_out),
        .i_rdy_in    (rdy_in),
        .o_busy      (busy),
        .o_run_done  (run_done),
        .o_err       (err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and wait (bounded) for it to be accepted; returns just after the
    // accepting edge.
    task automatic send_cmd(input logic [CW-1:0] cnt);
        int waited;
        waited    = 0;
        cmd_valid = 1'b1;
        cmd_count = cnt;
        while (!cmd_ready && waited < 10) begin
            tick();
            waited++;
        end
        check_eq("cmd_ready_wait", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        resetn    = 1'b1;
        cmd_valid = 1'b0;
        cmd_count = '0;
        ap_ready  = 1'b0;
        ap_done   = 1'b0;
        ap_idle   = 1'b1;
        data_in   = '0;
        vld_in    = 1'b0;
        rdy_in    = 1'b0;

        // Reset state
        #3 resetn = 1'b0;
        #1;
        check_eq("rst_ap_start", ap_start, 0);
        check_eq("rst_vld_out", vld_out, 0);
        check_eq("rst_run_done", run_done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_data_out", data_out, 0);
        tick();
        tick();
        resetn = 1'b1;

        // Zero-length run: stays idle, run_done pulse next cycle
        send_cmd(0);
        check_eq("cnt0_run_done", run_done, 1);
        check_eq("cnt0_busy", busy, 0);
        check_eq("cnt0_ap_start", ap_start, 0);
        tick();
        check_eq("cnt0_run_done_low", run_done, 0);

        // Three invocations; latest vld_in value (9) is sent from the held register
        send_cmd(3);
        for (int run = 0; run < 3; run++) begin
            check_eq("r3_ap_start", ap_start, 1);
            ap_ready = 1'b1;
            tick();
            ap_ready = 1'b0;
            check_eq("r3_ap_start_low", ap_start, 0);
            check_eq("r3_busy", busy, 1);
            vld_in = 1'b1;
            data_in = 5;
            tick();
            data_in = 7;
            tick();
            data_in = 9;
            tick();
            vld_in = 1'b0;
            ap_done = 1'b1;
            tick();
            ap_done = 1'b0;
            check_eq("r3_vld_out", vld_out, 1);
            check_eq("r3_data_out", data_out, 9);
            rdy_in = 1'b1;
            tick();
            rdy_in = 1'b0;
            check_eq("r3_vld_out_low", vld_out, 0);
        end
        check_eq("r3_run_done", run_done, 1);
        check_eq("r3_busy_end", busy, 0);
        tick();
        check_eq("r3_run_done_low", run_done, 0);

        // No vld_in at all: no output, run_done the cycle after ap_done
        send_cmd(1);
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        tick();
        tick();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check_eq("nov_vld_out", vld_out, 0);
        check_eq("nov_run_done", run_done, 1);
        tick();
        check_eq("nov_run_done_low", run_done, 0);
        check_eq("nov_vld_out2", vld_out, 0);

        // ap_ready low for 4 cycles: ap_start high for 5
        send_cmd(1);
        for (int i = 0; i < 4; i++) begin
            check_eq("hold_ap_start", ap_start, 1);
            tick();
        end
        check_eq("hold_ap_start5", ap_start, 1);
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        check_eq("hold_ap_start_drop", ap_start, 0);
        vld_in = 1'b1;
        data_in = 11;
        ap_done = 1'b1;
        tick();
        vld_in = 1'b0;
        ap_done = 1'b0;
        check_eq("direct_vld_out", vld_out, 1);
        check_eq("direct_data_out", data_out, 11);

        // Output back-pressure: everything stays put, stray ap_done ignored
        for (int i = 0; i < 10; i++) begin
            data_in = 100 + i;
            vld_in = 1'b1;
            ap_done = (i == 3);
            tick();
            check_eq("stall_vld_out", vld_out, 1);
            check_eq("stall_data_out", data_out, 11);
            check_eq("stall_ap_start", ap_start, 0);
        end
        vld_in = 1'b0;
        ap_done = 1'b0;
        rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;
        check_eq("stall_release_vld", vld_out, 0);
        check_eq("stall_run_done", run_done, 1);

        // ever_valid from run 1 must not leak into run 2 (ready+done, no vld_in)
        send_cmd(2);
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        vld_in = 1'b1;
        data_in = 33;
        tick();
        vld_in = 1'b0;
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check_eq("ev_vld_out", vld_out, 1);
        check_eq("ev_data_out", data_out, 33);
        rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;
        check_eq("ev_ap_start2", ap_start, 1);
        ap_ready = 1'b1;
        ap_done = 1'b1;
        tick();
        ap_ready = 1'b0;
        ap_done = 1'b0;
        check_eq("ev_skip_vld_out", vld_out, 0);
        check_eq("ev_run_done", run_done, 1);
        check_eq("ev_busy", busy, 0);

        // ap_ready, ap_done and vld_in together in START
        send_cmd(1);
        ap_ready = 1'b1;
        ap_done = 1'b1;
        vld_in = 1'b1;
        data_in = 21;
        tick();
        ap_ready = 1'b0;
        ap_done = 1'b0;
        vld_in = 1'b0;
        check_eq("same_vld_out", vld_out, 1);
        check_eq("same_data_out", data_out, 21);
        rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;
        check_eq("same_run_done", run_done, 1);

        // ap_done while idle is ignored
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check_eq("idle_done_busy", busy, 0);
        check_eq("idle_done_vld", vld_out, 0);
        check_eq("idle_done_start", ap_start, 0);

        // Max count (2^CW-1) runs exactly that many invocations
        send_cmd(15);
        ap_ready = 1'b1;
        ap_done = 1'b1;
        starts = 0;
        guard = 0;
        while (!run_done && guard < 40) begin
            if (ap_start) starts++;
            tick();
            guard++;
        end
        ap_ready = 1'b0;
        ap_done = 1'b0;
        check_eq("max_starts", starts, 15);
        check_eq("max_run_done", run_done, 1);
        check_eq("max_busy", busy, 0);

        // Reset during WAIT of run 2 of 4
        send_cmd(4);
        ap_ready = 1'b1;
        ap_done = 1'b1;
        vld_in = 1'b1;
        data_in = 44;
        tick();
        ap_ready = 1'b0;
        ap_done = 1'b0;
        vld_in = 1'b0;
        check_eq("mid_vld_out", vld_out, 1);
        check_eq("mid_data_out", data_out, 44);
        rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;
        check_eq("mid_ap_start2", ap_start, 1);
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        check_eq("mid_busy_wait", busy, 1);
        vld_in = 1'b1;
        data_in = 66;
        tick();
        vld_in = 1'b0;
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_ap_start", ap_start, 0);
        check_eq("mid_rst_vld_out", vld_out, 0);
        check_eq("mid_rst_run_done", run_done, 0);
        check_eq("mid_rst_data_out", data_out, 0);
        check_eq("mid_rst_err", err, 0);
        tick();
        tick();
        check_eq("mid_rst_no_done", run_done, 0);
        resetn = 1'b1;
        send_cmd(1);
        check_eq("post_rst_ap_start", ap_start, 1);
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        vld_in = 1'b1;
        data_in = 77;
        ap_done = 1'b1;
        tick();
        vld_in = 1'b0;
        ap_done = 1'b0;
        check_eq("post_rst_vld_out", vld_out, 1);
        check_eq("post_rst_data_out", data_out, 77);
        rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;
        check_eq("post_rst_run_done", run_done, 1);

`ifdef ACC_RUN_CTRL_TIMEOUT_EN
        // Watchdog: 16 WAIT cycles without ap_done aborts the run
        send_cmd(1);
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        guard = 0;
        while (!run_done && guard < 40) begin
            tick();
            guard++;
        end
        check_eq("wd_cycles", guard, 16);
        check_eq("wd_err", err, 1);
        check_eq("wd_vld_out", vld_out, 0);
        check_eq("wd_busy", busy, 0);
        send_cmd(1);
        check_eq("wd_err_cleared", err, 0);
        ap_ready = 1'b1;
        ap_done = 1'b1;
        tick();
        ap_ready = 1'b0;
        ap_done = 1'b0;
        check_eq("wd_next_run_done", run_done, 1);
`else
        check_eq("no_wd_err", err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/acc_run_ctrl.md
ACC_RUN_CTRL -- requirements
Module: acc_run_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the accelerator scalar output.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the invocation count.
REQ-003 SHALL have parameter TIMEOUT, default 1024, the watchdog limit in cycles (used only under REQ-027).
REQ-004 clk  in  1  single clock, shared with the accelerator; all logic rising-edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1 / cmd_ready  out  1 / cmd_count  in  CNT_WIDTH: run request, valid/ready handshake.
REQ-007 ap_start  out  1 / ap_ready  in  1 / ap_done  in  1 / ap_idle  in  1: accelerator ap_ctrl_hs bus.
REQ-008 data_in  in  DATA_WIDTH / vld_in  in  1: accelerator scalar output and its valid.
REQ-009 data_out  out  DATA_WIDTH / vld_out  out  1 / rdy_in  in  1: result stream to the adapter.
REQ-010 busy  out  1 (state != IDLE); run_done  out  1 (one-cycle pulse at end of run); err  out  1 (sticky timeout flag).

Function
REQ-011 SHALL implement states IDLE, START, WAIT and OUT.
REQ-012 IDLE: cmd_ready=1; on cmd_valid, clear err, load remaining=cmd_count and go to START; if cmd_count==0, stay in IDLE and pulse run_done the next cycle.
REQ-013 START: ap_start=1; hold it until ap_ready is sampled high; clear ever_valid; then go to WAIT.
REQ-014 START with ap_ready and ap_done both high in one cycle: treat as done (REQ-016) without entering WAIT.
REQ-015 WAIT: ap_start=0; each cycle vld_in=1, latch data_in into data_reg (last value wins) and set ever_valid.
REQ-016 On ap_done: if vld_in=1 that cycle, present data_in; else if ever_valid, present data_reg; go to OUT; if neither, go to the next-step rule (REQ-018) without emitting output.
REQ-017 OUT: vld_out=1 and data_out stable until rdy_in=1; the handshake completes in the cycle vld_out&rdy_in.
REQ-018 Next step after a completed output or a skipped one: decrement remaining; if the new value is 0, go to IDLE and pulse run_done; else go to START.
REQ-019 ap_done pulses outside START/WAIT SHALL be ignored; ap_idle is status only and SHALL NOT affect transitions.
REQ-020 remaining SHALL never wrap; a count of 2^CNT_WIDTH-1 runs exactly that many invocations.
REQ-021 Latency: ap_start SHALL assert the cycle after cmd acceptance; vld_out SHALL assert the cycle after ap_done.
REQ-022 vld_out SHALL be registered; data_out SHALL NOT change while vld_out=1 and rdy_in=0.

Reset
REQ-023 resetn low SHALL immediately force state=IDLE, ap_start=0, vld_out=0, run_done=0, err=0, busy=0, remaining=0, ever_valid=0 and data_out=0.
REQ-024 Reset mid-run SHALL abandon the run with no run_done pulse; after release, the block SHALL accept a new command in the first cycle.
REQ-025 Reset deassertion SHALL be synchronised internally with a 2-flop release on clk.

Configuration
REQ-026 Macro ACC_RUN_CTRL_TIMEOUT_EN SHALL select whether the watchdog is built.
REQ-027 Defined: a counter runs in WAIT; if it reaches TIMEOUT-1 cycles without ap_done, set err, go to IDLE and pulse run_done, with no output for that invocation and remaining runs discarded.
REQ-028 Undefined: no counter is built, err is tied to 0, and WAIT lasts indefinitely.

Verification
REQ-029 cmd_count=3; each invocation gives vld_in with 5,7,9 and then ap_done -> three vld_out beats with data 9 (x3 latest per run), then a run_done pulse.
REQ-030 cmd_count=1; vld_in never asserts; ap_done -> no vld_out, run_done one cycle after ap_done.
REQ-031 ap_ready held low 4 cycles in START -> ap_start stays high for 5 cycles, then drops.
REQ-032 rdy_in=0 for 10 cycles during OUT -> vld_out and data_out stable; no new ap_start until handshake.
REQ-033 With ACC_RUN_CTRL_TIMEOUT_EN defined and TIMEOUT=16, no ap_done -> err=1 and run_done after 16 WAIT cycles; the next accepted cmd clears err.
REQ-034 resetn low during WAIT of run 2 of 4 -> all outputs 0 immediately; new cmd_count=1 is accepted and completes normally.
